poly_addr_seq: RTL

- Self-timed, parametrised address sequencer for one butterfly unit (BU) in the Kyber polynomial arithmetic core.
- Has its own stage and butterfly counters, so no external clock counter is needed.
- Supports a start/busy/done handshake and a stall input.
- Issues read pairs, twiddle addresses and pipeline-delayed write pairs for NTT, INVNTT, MULT and ADDSUB.
- Inserts drain bubbles between NTT/INVNTT stages so the next stage never reads data that has not yet been written back.

---
 rtl/poly_addr_seq.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/poly_addr_seq.sv
// Butterfly address sequencer: read pairs, twiddle index and delayed write pairs for NTT/INVNTT/MULT/ADDSUB.
// Latency: first rd_en one cycle after accept; wr pair follows its rd pair by PIPE_DEPTH unstalled cycles.
// Backpressure: stall freezes counters, FSM and write pipeline; both enables drop, addresses hold.
module poly_addr_seq #(
    parameter int LOGN       = 8,
    parameter int STAGES     = 7,
    parameter int PIPE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-2:0] tw_addr,
    output logic            tw_neg,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output logic [2:0]      stage
);

    localparam int KW  = $clog2(LOGN) + 2;
    localparam int DW  = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int TWW = LOGN - 1;

    localparam logic [LOGN-1:0] ONE_N = LOGN'(1);
    localparam logic [TWW-1:0]  ONE_T = TWW'(1);
    localparam logic [TWW-1:0]  TW_Q  = TWW'(1 << (LOGN - 2));

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FLUSH,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        M_NTT    = 2'd0,
        M_INTT   = 2'd1,
        M_MULT   = 2'd2,
        M_ADDSUB = 2'd3
    } mode_t;

    typedef struct packed {
        logic            vld;
        logic [LOGN-1:0] a;
        logic [LOGN-1:0] b;
    } wr_ent_t;

    state_t          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic [LOGN-1:0] b_q, b_d;
    logic [2:0]      stage_q, stage_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            busy_d, done_d;
    logic            issue;

    wr_ent_t         pipe_q [PIPE_DEPTH];
    logic            pipe_empty;

    logic [LOGN-1:0] b_last;
    logic            multi_stage;
    logic            last_stage;

    assign b_last      = (mode_q == M_ADDSUB) ? {LOGN{1'b1}} : {1'b0, {(LOGN-1){1'b1}}};
    assign multi_stage = (mode_q == M_NTT) || (mode_q == M_INTT);
    assign last_stage  = (stage_q == 3'(STAGES - 1));

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (pipe_q[i].vld) pipe_empty = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_NTT;
            b_q     <= '0;
            stage_q <= '0;
            dcnt_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            b_q     <= b_d;
            stage_q <= stage_d;
            dcnt_q  <= dcnt_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        b_d     = b_q;
        stage_d = stage_q;
        dcnt_d  = dcnt_q;
        busy_d  = busy_q_hold();
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    mode_d  = mode_t'(mode);
                    b_d     = '0;
                    stage_d = '0;
                    dcnt_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (b_q == b_last) begin
                        b_d = '0;
                        if (multi_stage && !last_stage) begin
                            state_d = S_DRAIN;
                            dcnt_d  = '0;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        b_d = b_q + ONE_N;
                    end
                end
            end
            S_DRAIN: begin
                // bubbles let the last writes of this stage land before the next stage reads
                if (!stall) begin
                    if (dcnt_q == DW'(PIPE_DEPTH - 1)) begin
                        dcnt_d  = '0;
                        stage_d = stage_q + 3'd1;
                        state_d = S_ISSUE;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (!stall && pipe_empty) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    function automatic logic busy_q_hold();
        return busy;
    endfunction

    // ------------------------------------------------------------------
    // Address generation for the pair selected by (mode, stage, b)
    // ------------------------------------------------------------------
    logic [KW-1:0]   k;
    logic [LOGN-1:0] span;
    logic [LOGN-1:0] lo_mask;
    logic [LOGN-1:0] g_full;
    logic [LOGN-1:0] bf_a;
    logic [LOGN-1:0] bf_b;
    logic [TWW-1:0]  tw_ntt;
    logic [TWW-1:0]  tw_intt;
    logic [LOGN-1:0] issue_a;
    logic [LOGN-1:0] issue_b;
    logic [TWW-1:0]  issue_tw;
    logic            issue_neg;

    always_comb begin
        if (mode_q == M_INTT) begin
            k = KW'(LOGN - STAGES) + KW'(stage_q);
        end else begin
            k = KW'(LOGN - 1) - KW'(stage_q);
        end
        span    = ONE_N << k;
        lo_mask = span - ONE_N;
        g_full  = b_q >> k;
        // a = g*2*len + o: a zero bit inserted into b at position log2(len)
        bf_a    = ((g_full << 1) << k) | (b_q & lo_mask);
        bf_b    = bf_a | span;
        tw_ntt  = (ONE_T << stage_q) + g_full[TWW-1:0];
        // N/len may be 2^(LOGN-1), which wraps to 0 here; the difference is still exact mod 2^(LOGN-1)
        tw_intt = (ONE_T << (KW'(LOGN) - k)) - ONE_T - g_full[TWW-1:0];
    end

    always_comb begin
        issue_a   = b_q;
        issue_b   = b_q;
        issue_tw  = '0;
        issue_neg = 1'b0;
        case (mode_q)
            M_NTT: begin
                issue_a  = bf_a;
                issue_b  = bf_b;
                issue_tw = tw_ntt;
            end
            M_INTT: begin
                issue_a  = bf_a;
                issue_b  = bf_b;
                issue_tw = tw_intt;
            end
            M_MULT: begin
                issue_a   = {b_q[LOGN-2:0], 1'b0};
                issue_b   = {b_q[LOGN-2:0], 1'b1};
                issue_tw  = TW_Q + b_q[LOGN-1:1];
                issue_neg = b_q[0];
            end
            default: begin
                issue_a  = b_q;
                issue_b  = b_q;
                issue_tw = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered read outputs and write-back delay line
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            tw_neg    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr_a <= '0;
            wr_addr_b <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (stall) begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
        end else begin
            rd_en <= issue;
            if (issue) begin
                rd_addr_a <= issue_a;
                rd_addr_b <= issue_b;
                tw_addr   <= issue_tw;
                tw_neg    <= issue_neg;
            end
            pipe_q[0] <= {issue, issue_a, issue_b};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            wr_en <= pipe_q[PIPE_DEPTH-1].vld;
            if (pipe_q[PIPE_DEPTH-1].vld) begin
                wr_addr_a <= pipe_q[PIPE_DEPTH-1].a;
                wr_addr_b <= pipe_q[PIPE_DEPTH-1].b;
            end
        end
    end

    assign stage = stage_q;

endmodule
